// File: rtl/serial_rx_port.sv
`default_nettype none
//============================================================================
// Module   : serial_rx_port
// Purpose  : Oversampled serial byte receiver. Each frame is
//            1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//            Every bit lasts BIT_CYCLES clocks. The start bit is checked at
//            mid-bit. Each later bit is sampled BIT_CYCLES clocks after the
//            previous sample. Received bytes are held in data_out. A
//            level-sensitive acknowledge handshake hands each byte to the
//            consumer.
// Ports    : CLK          system clock; all state changes on its rising edge
//            nCLR         asynchronous active-low reset
//            serial_in    serial line, idle high, already synchronous to CLK
//            acknowledge  consumer has taken data_out (level, active-high)
//            data_out     last received byte, stable while ready=1
//            ready        data_out holds an unacknowledged byte
//            busy         receiver FSM is not in IDLE (registered)
//            frame_err    sticky: the last frame had a bad stop bit
//            overrun      sticky: a good frame was dropped because ready=1
// Revision : 1.0  initial release
//============================================================================
module serial_rx_port #(
    parameter int BIT_CYCLES = 4    // clocks per bit; even and >= 4
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic       serial_in,
    input  logic       acknowledge,
    output logic [7:0] data_out,
    output logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                 c_cnt_w    = $clog2(BIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(BIT_CYCLES / 2);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one_cnt  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [7:0]         r_data;
    logic               r_ready, r_busy, r_frame_err, r_overrun;

    logic               w_start_ok;   // start bit confirmed at mid-bit
    logic               w_stop_good;  // stop sample was 1
    logic               w_stop_bad;   // stop sample was 0
    logic               w_ack;        // acknowledge that actually counts
    logic               w_load;       // new byte goes into data_out

    //------------------------------------------------------------------
    // Next-state and datapath decode
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_start_ok  = 1'b0;
        w_stop_good = 1'b0;
        w_stop_bad  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The edge that sees the first 0 counts as phase 1 of the
                // start bit, so the mid-bit check lands BIT_CYCLES/2 edges later.
                if (!serial_in) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_one_cnt;
                end
            end

            ST_START: begin
                if (r_cnt == c_half_cnt) begin
                    w_cnt_nxt = '0;
                    if (!serial_in) begin
                        w_state_nxt = ST_DATA;
                        w_idx_nxt   = 3'd0;
                        w_start_ok  = 1'b1;
                    end else begin
                        // The line went high again before mid-bit, so this was a glitch.
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one_cnt;
                end
            end

            ST_DATA: begin
                if (r_cnt == c_last_cnt) begin
                    w_cnt_nxt            = '0;
                    w_shift_nxt[r_idx]   = serial_in;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one_cnt;
                end
            end

            ST_STOP: begin
                if (r_cnt == c_last_cnt) begin
                    w_cnt_nxt = '0;
                    if (serial_in) begin
                        w_stop_good = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = ST_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one_cnt;
                end
            end

            ST_BREAK: begin
                // Wait for the line to return to idle. Otherwise a held-low line
                // would be read as a stream of start bits.
                if (serial_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    // An acknowledge on the same edge as a good stop frees the holding
    // register just in time. The new byte then loads instead of overrunning.
    assign w_ack  = acknowledge && r_ready;
    assign w_load = w_stop_good && (!r_ready || acknowledge);

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            // busy is decoded from the next state, so it changes on the same
            // edge as the state it reflects.
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    //------------------------------------------------------------------
    // Output holding register, handshake and sticky flags
    //------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= w_shift_nxt;
            end

            if (w_load) begin
                r_ready <= 1'b1;
            end else if (w_ack) begin
                r_ready <= 1'b0;
            end

            if (w_stop_good && r_ready && !acknowledge) begin
                r_overrun <= 1'b1;
            end else if (w_ack) begin
                r_overrun <= 1'b0;
            end

            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (w_start_ok) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign data_out  = r_data;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_port.sv
`default_nettype none
//============================================================================
// Module   : tb_serial_rx_port
// Purpose  : Self-checking bench for serial_rx_port. A frame-level
//            reference model places every sample point by arithmetic on the
//            edge that saw the start bit. A compare process checks all
//            outputs against it on every falling clock edge. Directed
//            scenarios pin exact values and latencies with literals. A
//            randomized phase follows, with noise between sample points and
//            random acknowledges.
// Revision : 1.0  initial release
//============================================================================
module tb_serial_rx_port;

    localparam int BC = 4;          // clocks per bit
    localparam int H  = BC / 2;     // edge offset of the start-bit check
    localparam int STOP_I = H + 9 * BC;

    logic       CLK = 1'b0;
    logic       nCLR;
    logic       serial_in;
    logic       acknowledge;
    logic [7:0] data_out;
    logic       ready, busy, frame_err, overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_rx_port #(.BIT_CYCLES(BC)) dut (
        .CLK        (CLK),
        .nCLR       (nCLR),
        .serial_in  (serial_in),
        .acknowledge(acknowledge),
        .data_out   (data_out),
        .ready      (ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    //------------------------------------------------------------------
    // Reference model. mode: 0 idle, 1 in frame (start at edge m_k), 2 break
    //------------------------------------------------------------------
    int         m_t = 0, m_k = 0, m_mode = 0;
    logic [7:0] m_sh = 8'h00, m_data = 8'h00;
    logic       m_ready = 0, m_busy = 0, m_ferr = 0, m_ovr = 0;

    always @(posedge CLK or negedge nCLR) begin
        int  d, n;
        logic line, ak, good, bad;
        if (!nCLR) begin
            m_mode = 0; m_data = 8'h00; m_ready = 0; m_busy = 0;
            m_ferr = 0; m_ovr = 0;
        end else begin
            m_t  = m_t + 1;
            line = serial_in;
            ak   = acknowledge;
            good = 0;
            bad  = 0;
            if (m_mode == 0) begin
                if (!line) begin m_mode = 1; m_k = m_t; end
            end else if (m_mode == 1) begin
                d = m_t - m_k;
                if (d == H) begin
                    if (line) m_mode = 0;
                    else      m_ferr = 0;
                end else if (d > H && (d - H) % BC == 0) begin
                    n = (d - H) / BC - 1;
                    if (n < 8) m_sh[n] = line;
                    else if (line) begin good = 1; m_mode = 0; end
                    else begin bad = 1; m_mode = 2; end
                end
            end else begin
                if (line) m_mode = 0;
            end
            if (good) begin
                if (m_ready && !ak) m_ovr = 1;
                else begin
                    m_data  = m_sh;
                    m_ready = 1;
                    if (ak) m_ovr = 0;
                end
            end else if (ak && m_ready) begin
                m_ready = 0;
                m_ovr   = 0;
            end
            if (bad) m_ferr = 1;
            m_busy = (m_mode != 0);
        end
    end

    //------------------------------------------------------------------
    // Per-cycle compare plus edge-number capture of output transitions
    //------------------------------------------------------------------
    int   rdy_rise_cyc = -1, busy_fall_cyc = -1, ferr_fall_cyc = -1;
    logic p_ready = 0, p_busy = 0, p_ferr = 0;

    always @(negedge CLK) begin
        checks = checks + 1;
        if ({data_out, ready, busy, frame_err, overrun} !==
            {m_data, m_ready, m_busy, m_ferr, m_ovr}) begin
            errors = errors + 1;
            $display("FAIL cycle_cmp edge=%0d got data=%h rdy=%b busy=%b ferr=%b ovr=%b expected data=%h rdy=%b busy=%b ferr=%b ovr=%b",
                     cyc, data_out, ready, busy, frame_err, overrun,
                     m_data, m_ready, m_busy, m_ferr, m_ovr);
        end
        if (!p_ready && ready)   rdy_rise_cyc  = cyc;
        if (p_busy && !busy)     busy_fall_cyc = cyc;
        if (p_ferr && !frame_err) ferr_fall_cyc = cyc;
        p_ready = ready;
        p_busy  = busy;
        p_ferr  = frame_err;
    end

    //------------------------------------------------------------------
    // Helpers
    //------------------------------------------------------------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit is_gap(input int i);
        return (i != 0) && (i != H) && !(i > H && (i - H) % BC == 0) && (i < STOP_I);
    endfunction

    // Drive ncyc clocks of one frame. Edge k+i samples the value set in loop
    // pass i. With rnd set, noise is added between sample points and
    // acknowledge is random. Otherwise acknowledge is a pulse on edge k+ack_rel.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int ack_rel, input bit rnd, input int ncyc);
        int   slot;
        logic v;
        for (int i = 0; i < ncyc; i++) begin
            slot = i / BC;
            if (slot == 0)      v = 1'b0;
            else if (slot == 9) v = stop_v;
            else                v = b[slot-1];
            if (rnd && is_gap(i) && $urandom_range(0, 2) == 0) v = ~v;
            serial_in   = v;
            acknowledge = rnd ? ($urandom_range(0, 3) == 0) : (i == ack_rel);
            tick();
        end
        acknowledge = 1'b0;
    endtask

    //------------------------------------------------------------------
    // Stimulus
    //------------------------------------------------------------------
    int t0;

    initial begin
        nCLR = 1'b0; serial_in = 1'b1; acknowledge = 1'b0;
        tick(); tick();
        chk("reset_data",  data_out, 8'h00);
        chk("reset_flags", {ready, busy, frame_err, overrun}, 4'b0000);
        nCLR = 1'b1;
        repeat (3) tick();

        // Clean 0xA5 and exact latency
        t0 = cyc + 1;
        send_frame(8'hA5, 1'b1, -1, 0, 10 * BC);
        chk("a5_data",      data_out, 8'hA5);
        chk("a5_ready",     ready, 1'b1);
        chk("a5_ferr",      frame_err, 1'b0);
        chk("a5_rdy_edge",  rdy_rise_cyc,  t0 + 38);
        chk("a5_busy_edge", busy_fall_cyc, t0 + 38);

        // Overrun while ready is held
        acknowledge = 1'b1; tick(); acknowledge = 1'b0;
        chk("ack_clears_ready", ready, 1'b0);
        send_frame(8'h3C, 1'b1, -1, 0, 10 * BC);
        send_frame(8'hC3, 1'b1, -1, 0, 10 * BC);
        chk("ovr_data",  data_out, 8'h3C);
        chk("ovr_flag",  {ready, overrun}, 2'b11);
        acknowledge = 1'b1; tick(); acknowledge = 1'b0;
        chk("ovr_ack", {ready, overrun}, 2'b00);

        // Bad stop bit, line held low, then recovery
        send_frame(8'h55, 1'b0, -1, 0, 10 * BC);
        serial_in = 1'b0;
        repeat (20) tick();
        chk("brk_flags", {ready, busy, frame_err}, 3'b011);
        serial_in = 1'b1; tick();
        chk("brk_exit",  {busy, frame_err}, 2'b01);
        repeat (2) tick();
        t0 = cyc + 1;
        send_frame(8'h0F, 1'b1, -1, 0, 10 * BC);
        chk("ferr_clear_edge", ferr_fall_cyc, t0 + 2);
        chk("rx_0f", data_out, 8'h0F);

        // One-cycle glitch on the idle line
        serial_in = 1'b0; tick();
        chk("glitch_busy", busy, 1'b1);
        serial_in = 1'b1; repeat (4) tick();
        chk("glitch_state", {data_out, ready, busy, frame_err, overrun}, {8'h0F, 4'b1000});

        // Acknowledge on the stop-sample edge while ready is high
        send_frame(8'h81, 1'b1, STOP_I, 0, 10 * BC);
        chk("same_edge", {data_out, ready, overrun}, {8'h81, 2'b10});

        // Reset during data bit 4
        send_frame(8'h3A, 1'b1, -1, 0, H + 5 * BC);
        nCLR = 1'b0;
        #1;
        chk("async_rst", {data_out, ready, busy, frame_err, overrun}, 12'h000);
        tick(); tick();
        serial_in = 1'b1; nCLR = 1'b1;
        repeat (3) tick();
        chk("rst_idle", busy, 1'b0);
        send_frame(8'h7E, 1'b1, -1, 0, 10 * BC);
        chk("rx_7e", {data_out, ready}, {8'h7E, 1'b1});

        // Line already low when reset releases counts as a start bit
        nCLR = 1'b0; serial_in = 1'b0; tick();
        nCLR = 1'b1;
        t0 = cyc + 1;
        send_frame(8'h99, 1'b1, -1, 0, 10 * BC);
        chk("rel_low_data", data_out, 8'h99);
        chk("rel_low_edge", rdy_rise_cyc, t0 + 38);

        // Randomized traffic
        for (int f = 0; f < 60; f++) begin
            int gap;
            logic sv;
            gap = $urandom_range(1, 6);
            for (int g = 0; g < gap; g++) begin
                serial_in   = 1'b1;
                acknowledge = ($urandom_range(0, 2) == 0);
                tick();
            end
            acknowledge = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                serial_in = 1'b0; tick();
                serial_in = 1'b1; repeat (3) tick();
            end
            sv = ($urandom_range(0, 5) != 0);
            send_frame(8'($urandom_range(0, 255)), sv, -1, 1, 10 * BC);
            if (!sv) begin
                serial_in = 1'b0;
                repeat ($urandom_range(0, 5)) tick();
                serial_in = 1'b1; tick();
            end
        end
        serial_in = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
